// File: rtl/odelay_pkg.sv
// Shared types and string-parameter decoding for the odelay_bank_asic output delay bank.
package odelay_pkg;

    typedef enum logic [1:0] {
        DT_FIXED    = 2'd0,
        DT_VARIABLE = 2'd1,
        DT_VAR_LOAD = 2'd2
    } delay_type_e;

    typedef enum logic {
        UM_ASYNC = 1'b0,
        UM_SYNC  = 1'b1
    } update_mode_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } sync_state_e;

    // Unrecognised strings fall back to the most permissive delay type.
    function automatic delay_type_e str2delay_type(input string s);
        if (s == "FIXED") return DT_FIXED;
        if (s == "VARIABLE") return DT_VARIABLE;
        return DT_VAR_LOAD;
    endfunction

    function automatic update_mode_e str2update_mode(input string s);
        if (s == "SYNC") return UM_SYNC;
        return UM_ASYNC;
    endfunction

endpackage

// File: rtl/odelay_chan_asic.sv
// One delay channel: tap counter, SYNC apply FSM, delay line and output register.
// Define ODELAY_SATURATE_EN to make INC/DEC saturate at MAX_TAP/0 instead of wrapping.
module odelay_chan_asic
    import odelay_pkg::*;
#(
    parameter int           TAP_W    = 5,
    parameter int           MAX_TAP  = 31,
    parameter int           INIT_TAP = 0,
    parameter delay_type_e  DT       = DT_VAR_LOAD,
    parameter update_mode_e UM       = UM_ASYNC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_vtc,
    input  logic             ce,
    input  logic             inc,
    input  logic             load,
    input  logic [TAP_W-1:0] cnt_in,
    input  logic             odata,
    output logic             dataout,
    output logic [TAP_W-1:0] cnt_out,
    output sync_state_e      state_o
);

`ifdef ODELAY_SATURATE_EN
    localparam bit SATURATE = 1'b1;
`else
    localparam bit SATURATE = 1'b0;
`endif

    localparam logic [TAP_W-1:0] MAX_T  = TAP_W'(MAX_TAP);
    localparam logic [TAP_W-1:0] INIT_T = TAP_W'(INIT_TAP);

    logic [MAX_TAP:0] shreg_q, shreg_d;
    logic [TAP_W-1:0] tap_q, tap_d;
    logic [TAP_W-1:0] target_q, target_d;
    sync_state_e      state_q, state_d;
    logic             dout_q, dout_d;

    logic             cmd_valid;
    logic [TAP_W-1:0] base, new_tap, tgt;

    function automatic logic pick(input logic [MAX_TAP:0] v, input logic [TAP_W-1:0] t);
        logic [MAX_TAP:0] s;
        s = v >> t;
        return s[0];
    endfunction

    always_comb begin
        cmd_valid = !en_vtc && (DT != DT_FIXED) && (load || ce);
        base      = (state_q == S_WAIT) ? target_q : tap_q;
        new_tap   = base;
        if (load) begin
            if (DT == DT_VAR_LOAD) new_tap = (cnt_in > MAX_T) ? MAX_T : cnt_in;
            else                   new_tap = INIT_T;
        end else if (inc) begin
            if (base == MAX_T) new_tap = SATURATE ? MAX_T : '0;
            else               new_tap = base + TAP_W'(1);
        end else begin
            if (base == '0) new_tap = SATURATE ? '0 : MAX_T;
            else            new_tap = base - TAP_W'(1);
        end
        tgt = cmd_valid ? new_tap : target_q;

        shreg_d  = {shreg_q[MAX_TAP-1:0], odata};
        dout_d   = pick(shreg_q, tap_q);
        tap_d    = tap_q;
        target_d = target_q;
        state_d  = state_q;

        if (UM == UM_ASYNC) begin
            if (cmd_valid) begin
                tap_d    = new_tap;
                target_d = new_tap;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        target_d = new_tap;
                        if (new_tap != tap_q) state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Switch only when old and new taps show the same bit, so DATAOUT never glitches.
                    target_d = tgt;
                    if (pick(shreg_q, tgt) == pick(shreg_q, tap_q)) begin
                        tap_d   = tgt;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q  <= '0;
            tap_q    <= INIT_T;
            target_q <= INIT_T;
            state_q  <= S_IDLE;
            dout_q   <= 1'b0;
        end else begin
            shreg_q  <= shreg_d;
            tap_q    <= tap_d;
            target_q <= target_d;
            state_q  <= state_d;
            dout_q   <= dout_d;
        end
    end

    assign dataout = dout_q;
    assign cnt_out = tap_q;
    assign state_o = state_q;

endmodule

// File: rtl/odelay_bank_asic.sv
// Multi-channel cycle-based output delay bank; replicates odelay_chan_asic and slices the buses.
// Saturating tap arithmetic is selected with ODELAY_SATURATE_EN (see odelay_chan_asic).
module odelay_bank_asic
    import odelay_pkg::*;
#(
    parameter int    NUM_CH      = 4,
    parameter int    TAP_W       = 5,
    parameter int    MAX_TAP     = 31,
    parameter string DELAY_TYPE  = "VAR_LOAD",
    parameter string UPDATE_MODE = "ASYNC",
    parameter int    INIT_TAP    = 0
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    EN_VTC,
    input  logic [NUM_CH-1:0]       CE,
    input  logic [NUM_CH-1:0]       INC,
    input  logic [NUM_CH-1:0]       LOAD,
    input  logic [NUM_CH*TAP_W-1:0] CNTVALUEIN,
    input  logic [NUM_CH-1:0]       ODATAIN,
    output logic [NUM_CH-1:0]       DATAOUT,
    output logic [NUM_CH*TAP_W-1:0] CNTVALUEOUT,
    output logic [NUM_CH-1:0]       PEND
);

    localparam delay_type_e  DT = str2delay_type(DELAY_TYPE);
    localparam update_mode_e UM = str2update_mode(UPDATE_MODE);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        sync_state_e st;

        odelay_chan_asic #(
            .TAP_W   (TAP_W),
            .MAX_TAP (MAX_TAP),
            .INIT_TAP(INIT_TAP),
            .DT      (DT),
            .UM      (UM)
        ) u_chan (
            .clk    (CLK),
            .rst    (RST),
            .en_vtc (EN_VTC),
            .ce     (CE[c]),
            .inc    (INC[c]),
            .load   (LOAD[c]),
            .cnt_in (CNTVALUEIN[c*TAP_W +: TAP_W]),
            .odata  (ODATAIN[c]),
            .dataout(DATAOUT[c]),
            .cnt_out(CNTVALUEOUT[c*TAP_W +: TAP_W]),
            .state_o(st)
        );

        assign PEND[c] = (st == S_WAIT);
    end

endmodule
